sdes_job_sched: RTL and testbench

Controller that shares one `SDES_top` encrypt/decrypt core between two requesters. Each requester submits 8-bit blocks tagged encrypt or decrypt over a valid/ready handshake. The block round-robin arbitrates between them, drives the core enables and data for one job at a time, and waits a fixed core latency. It then returns the captured result to the originating requester. It also owns the 10-bit key register that feeds the core, so key updates can never land mid-job.

---
 rtl/sdes_pkg.sv | 23 ++
 rtl/sdes_rr_arb2.sv | 34 +++
 rtl/sdes_job_sched.sv | 157 +++++++++++++++
 tb/tb_sdes_job_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdes_pkg
// Purpose : Shared types and widths for the S-DES job scheduler
// Rev     : 1.0
// ============================================================================
package sdes_pkg;

  localparam int KEY_W = 10;
  localparam int BLK_W = 8;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sdes_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : sdes_rr_arb2
// Purpose : Two-requester round-robin arbiter with one registered priority bit
// Rev     : 1.0
// ============================================================================
module sdes_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  // High means requester 1 wins a tie.
  logic r_prio;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (i_advance && (|o_gnt)) begin
      r_prio <= o_gnt[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdes_job_sched.sv
`default_nettype none
// ============================================================================
// Module  : sdes_job_sched
// Purpose : Shares one S-DES core between two requesters, one job at a time
// Rev     : 1.0
// ============================================================================
module sdes_job_sched
  import sdes_pkg::*;
#(
  parameter int CORE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cfg_key_vld,
  input  logic [KEY_W-1:0] i_cfg_key,
  input  logic             i_req0_vld,
  input  logic             i_req1_vld,
  output logic             o_req0_rdy,
  output logic             o_req1_rdy,
  input  logic             i_req0_mode,
  input  logic             i_req1_mode,
  input  logic [BLK_W-1:0] i_req0_data,
  input  logic [BLK_W-1:0] i_req1_data,
  output logic             o_rsp0_vld,
  output logic             o_rsp1_vld,
  input  logic             i_rsp0_rdy,
  input  logic             i_rsp1_rdy,
  output logic [BLK_W-1:0] o_rsp_data,
  output logic [KEY_W-1:0] o_core_key,
  output logic             o_core_en_enc,
  output logic             o_core_en_dec,
  output logic [BLK_W-1:0] o_core_enc_pln_txt,
  output logic [BLK_W-1:0] o_core_dec_cipher_text,
  input  logic [BLK_W-1:0] i_core_enc_cipher_text,
  input  logic [BLK_W-1:0] i_core_dec_pln_txt,
  output logic             o_busy,
  output logic [15:0]      o_job_cnt
);

  localparam logic [1:0] c_IDLE     = ST_IDLE;
  localparam logic [1:0] c_ISSUE    = ST_ISSUE;
  localparam logic [1:0] c_WAIT     = ST_WAIT;
  localparam logic [1:0] c_RESP     = ST_RESP;
  localparam logic [3:0] c_LAT_LAST = 4'(CORE_LAT - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_lat_cnt;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] r_key_pend_val;
  logic             r_key_pend;
  logic             r_mode;
  logic             r_owner;
  logic [BLK_W-1:0] r_data;
  logic [BLK_W-1:0] r_rsp_data;
  logic [15:0]      r_job_cnt;

  logic             w_idle;
  logic             w_key_load;
  logic [1:0]       w_arb_req;
  logic [1:0]       w_gnt;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_take;

  // A key load owns the IDLE cycle, so the arbiter sees no requests then.
  assign w_idle     = (r_state == c_IDLE);
  assign w_key_load = w_idle && (i_cfg_key_vld || r_key_pend);
  assign w_arb_req  = (w_idle && !w_key_load) ? {i_req1_vld, i_req0_vld} : 2'b00;
  assign w_accept   = |w_gnt;
  assign w_capture  = (r_state == c_WAIT) && (r_lat_cnt == c_LAT_LAST);
  assign w_rsp_take = (r_state == c_RESP) && (r_owner ? i_rsp1_rdy : i_rsp0_rdy);

  sdes_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_arb_req),
    .i_advance (w_accept),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_lat_cnt <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE:  if (w_accept) r_state <= c_ISSUE;
        c_ISSUE: begin
          r_lat_cnt <= 4'd0;
          r_state   <= c_WAIT;
        end
        c_WAIT: begin
          if (w_capture) r_state <= c_RESP;
          else           r_lat_cnt <= r_lat_cnt + 4'd1;
        end
        c_RESP:  if (w_rsp_take) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_ENC;
      r_owner <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_mode  <= w_gnt[1] ? i_req1_mode : i_req0_mode;
      r_owner <= w_gnt[1];
      r_data  <= w_gnt[1] ? i_req1_data : i_req0_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_job_cnt  <= 16'd0;
    end else begin
      if (w_capture) begin
        r_rsp_data <= (r_mode == MODE_DEC) ? i_core_dec_pln_txt : i_core_enc_cipher_text;
      end
      if (w_rsp_take) begin
        r_job_cnt <= r_job_cnt + 16'd1;
      end
    end
  end

  // Writes outside IDLE are parked; the newest write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key          <= '0;
      r_key_pend     <= 1'b0;
      r_key_pend_val <= '0;
    end else if (w_key_load) begin
      r_key      <= i_cfg_key_vld ? i_cfg_key : r_key_pend_val;
      r_key_pend <= 1'b0;
    end else if (i_cfg_key_vld) begin
      r_key_pend     <= 1'b1;
      r_key_pend_val <= i_cfg_key;
    end
  end

  assign o_req0_rdy             = w_gnt[0];
  assign o_req1_rdy             = w_gnt[1];
  assign o_rsp0_vld             = (r_state == c_RESP) && !r_owner;
  assign o_rsp1_vld             = (r_state == c_RESP) && r_owner;
  assign o_rsp_data             = r_rsp_data;
  assign o_core_key             = r_key;
  assign o_core_en_enc          = (r_state == c_ISSUE) && (r_mode == MODE_ENC);
  assign o_core_en_dec          = (r_state == c_ISSUE) && (r_mode == MODE_DEC);
  assign o_core_enc_pln_txt     = r_data;
  assign o_core_dec_cipher_text = r_data;
  assign o_busy                 = !w_idle;
  assign o_job_cnt              = r_job_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdes_job_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdes_job_sched
// Purpose : Self-checking bench with an S-DES core stand-in and timing model
// Rev     : 1.0
// ============================================================================
module tb_sdes_job_sched;

  localparam int         LAT   = 4;
  localparam logic [9:0] KEY_A = 10'b1010000010;
  localparam logic [1:0] S0_T [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                       2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1_T [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                       2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_key_vld = 1'b0;
  logic [9:0] cfg_key = '0;
  logic       req0_vld = 1'b0, req1_vld = 1'b0;
  logic       req0_mode = 1'b0, req1_mode = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       rsp0_rdy = 1'b1, rsp1_rdy = 1'b1;
  logic       req0_rdy, req1_rdy, rsp0_vld, rsp1_vld;
  logic [7:0] rsp_data, core_enc_pt, core_dec_ct, core_enc_ct, core_dec_pt;
  logic [9:0] core_key;
  logic       core_en_enc, core_en_dec, busy;
  logic [15:0] job_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdes_job_sched #(.CORE_LAT(LAT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_cfg_key_vld          (cfg_key_vld),
    .i_cfg_key              (cfg_key),
    .i_req0_vld             (req0_vld),
    .i_req1_vld             (req1_vld),
    .o_req0_rdy             (req0_rdy),
    .o_req1_rdy             (req1_rdy),
    .i_req0_mode            (req0_mode),
    .i_req1_mode            (req1_mode),
    .i_req0_data            (req0_data),
    .i_req1_data            (req1_data),
    .o_rsp0_vld             (rsp0_vld),
    .o_rsp1_vld             (rsp1_vld),
    .i_rsp0_rdy             (rsp0_rdy),
    .i_rsp1_rdy             (rsp1_rdy),
    .o_rsp_data             (rsp_data),
    .o_core_key             (core_key),
    .o_core_en_enc          (core_en_enc),
    .o_core_en_dec          (core_en_dec),
    .o_core_enc_pln_txt     (core_enc_pt),
    .o_core_dec_cipher_text (core_dec_ct),
    .i_core_enc_cipher_text (core_enc_ct),
    .i_core_dec_pln_txt     (core_dec_pt),
    .o_busy                 (busy),
    .o_job_cnt              (job_cnt)
  );

  // ---------------- reference S-DES ----------------
  function automatic logic [7:0] p8(input logic [9:0] x);
    return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] b, input logic [7:0] sk);
    logic [7:0] x;
    logic [3:0] s;
    x = {b[0], b[3], b[2], b[1], b[2], b[1], b[0], b[3]} ^ sk;
    s = {S0_T[{x[7], x[4], x[6], x[5]}], S1_T[{x[3], x[0], x[2], x[1]}]};
    return {b[7:4] ^ {s[2], s[0], s[1], s[3]}, b[3:0]};
  endfunction

  function automatic logic [7:0] sdes(input logic [9:0] k, input logic dec, input logic [7:0] d);
    logic [9:0] p, a, c;
    logic [7:0] k1, k2, b;
    p  = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    a  = {p[8:5], p[9], p[3:0], p[4]};
    c  = {a[7:5], a[9:8], a[2:0], a[4:3]};
    k1 = dec ? p8(c) : p8(a);
    k2 = dec ? p8(a) : p8(c);
    b  = {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    b  = fk(b, k1);
    b  = fk({b[3:0], b[7:4]}, k2);
    return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
  endfunction

  // Core stand-in: result is only valid in the cycle ending LAT edges after the enable.
  logic [3:0] bc_cnt;
  logic       bc_dec;
  logic [7:0] bc_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_cnt <= 4'd0;
      bc_dec <= 1'b0;
      bc_res <= 8'h00;
    end else if (core_en_enc || core_en_dec) begin
      bc_cnt <= 4'd1;
      bc_dec <= core_en_dec;
      bc_res <= sdes(core_key, core_en_dec, core_en_dec ? core_dec_ct : core_enc_pt);
    end else if (bc_cnt != 4'd0 && bc_cnt <= 4'(LAT)) begin
      bc_cnt <= bc_cnt + 4'd1;
    end else begin
      bc_cnt <= 4'd0;
    end
  end
  assign core_enc_ct = (bc_cnt == 4'(LAT) && !bc_dec) ? bc_res : 8'hE1;
  assign core_dec_pt = (bc_cnt == 4'(LAT) &&  bc_dec) ? bc_res : 8'hD2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // ---------------- transaction-level model ----------------
  int         cyc;
  int         m_acc;
  bit         m_busy, m_owner, m_mode, m_pend, m_prio;
  logic [7:0] m_data, m_rsp;
  logic [9:0] m_key, m_pend_val;
  logic [15:0] m_jobs;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_mode = 0; m_pend = 0; m_prio = 0;
    m_acc = 0; m_data = '0; m_rsp = '0; m_key = '0; m_pend_val = '0; m_jobs = '0;
  endtask

  function automatic logic [1:0] m_grant();
    if (m_busy || cfg_key_vld || m_pend) return 2'b00;
    if (req0_vld && req1_vld) return m_prio ? 2'b10 : 2'b01;
    return {req1_vld, req0_vld};
  endfunction

  initial begin
    logic [1:0] g;
    bit         in_resp;
    model_reset();
    cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      g       = m_grant();
      in_resp = m_busy && (cyc >= m_acc + LAT + 2);
      chk("m_req0_rdy", 32'(req0_rdy), 32'(g[0]));
      chk("m_req1_rdy", 32'(req1_rdy), 32'(g[1]));
      chk("m_rsp0_vld", 32'(rsp0_vld), 32'(in_resp && !m_owner));
      chk("m_rsp1_vld", 32'(rsp1_vld), 32'(in_resp && m_owner));
      chk("m_en_enc", 32'(core_en_enc), 32'(m_busy && cyc == m_acc + 1 && !m_mode));
      chk("m_en_dec", 32'(core_en_dec), 32'(m_busy && cyc == m_acc + 1 && m_mode));
      chk("m_rsp_data", 32'(rsp_data), 32'(m_rsp));
      chk("m_core_key", 32'(core_key), 32'(m_key));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_job_cnt", 32'(job_cnt), 32'(m_jobs));
      if (m_busy) begin
        chk("m_enc_pt", 32'(core_enc_pt), 32'(m_data));
        chk("m_dec_ct", 32'(core_dec_ct), 32'(m_data));
      end
      @(posedge clk);
      if (!rst) begin
        if (!m_busy) begin
          g = m_grant();
          if (cfg_key_vld || m_pend) begin
            m_key  = cfg_key_vld ? cfg_key : m_pend_val;
            m_pend = 0;
          end else if (g != 2'b00) begin
            m_busy  = 1;
            m_acc   = cyc;
            m_owner = g[1];
            m_mode  = g[1] ? req1_mode : req0_mode;
            m_data  = g[1] ? req1_data : req0_data;
            m_prio  = g[0];
          end
        end else begin
          if (cfg_key_vld) begin
            m_pend     = 1;
            m_pend_val = cfg_key;
          end
          if (cyc == m_acc + LAT + 1) m_rsp = sdes(m_key, m_mode, m_data);
          if (cyc >= m_acc + LAT + 2 && (m_owner ? rsp1_rdy : rsp0_rdy)) begin
            m_jobs = m_jobs + 16'd1;
            m_busy = 0;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit who, input bit mode, input logic [7:0] d);
    int n;
    if (who) begin req1_vld = 1; req1_mode = mode; req1_data = d; end
    else     begin req0_vld = 1; req0_mode = mode; req0_data = d; end
    n = 0;
    @(negedge clk);
    while (!(who ? req1_rdy : req0_rdy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("send_accept");
    tick();
    if (who) req1_vld = 0; else req0_vld = 0;
  endtask

  task automatic wait_vld(input bit who, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(who ? rsp1_vld : rsp0_vld) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    bit order [4];
    int ng, n;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_key", 32'(core_key), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs", 32'(job_cnt), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    tick();
    rst = 0;
    tick();
    cfg_key_vld = 1; cfg_key = KEY_A;
    tick();
    cfg_key_vld = 0;
    @(negedge clk);
    chk("key_loaded", 32'(core_key), 32'(KEY_A));

    // Encrypt 0x97: accept cycle 0, enable cycle 1, response cycle LAT+2.
    tick();
    req0_vld = 1; req0_mode = 0; req0_data = 8'h97;
    @(negedge clk);
    chk("enc_accept", 32'(req0_rdy), 32'd1);
    tick();
    req0_vld = 0;
    @(negedge clk);
    chk("enc_en_enc", 32'(core_en_enc), 32'd1);
    chk("enc_en_dec", 32'(core_en_dec), 32'd0);
    for (int i = 2; i < LAT + 2; i++) begin
      tick();
      @(negedge clk);
      chk("enc_rsp_early", 32'(rsp0_vld), 32'd0);
    end
    tick();
    @(negedge clk);
    chk("enc_rsp_vld", 32'(rsp0_vld), 32'd1);
    chk("enc_rsp_data", 32'(rsp_data), 32'h38);
    tick();
    @(negedge clk);
    chk("enc_job_cnt", 32'(job_cnt), 32'd1);

    // Round trip through requester 1.
    tick();
    send(1, 1, 8'h38);
    wait_vld(1, "dec_rsp");
    chk("dec_rsp_data", 32'(rsp_data), 32'h97);
    chk("dec_rsp0_quiet", 32'(rsp0_vld), 32'd0);
    wait_idle("dec_idle");

    // Contention: both requesters held valid for four grants.
    tick();
    req0_vld = 1; req0_mode = 0; req0_data = 8'h11;
    req1_vld = 1; req1_mode = 1; req1_data = 8'h22;
    ng = 0; n = 0;
    while (ng < 4 && n < 200) begin
      @(negedge clk);
      if (req0_rdy || req1_rdy) begin
        order[ng] = req1_rdy;
        ng++;
      end
      tick();
      n++;
      if (ng == 4) begin
        req0_vld = 0; req1_vld = 0;
      end else begin
        req0_data = req0_data + 8'h13;
        req1_data = req1_data + 8'h29;
      end
    end
    if (ng < 4) timeout("rr_grants");
    for (int i = 0; i < ng; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
    wait_idle("rr_idle");

    // Backpressure on requester 0 while requester 1 waits.
    tick();
    rsp0_rdy = 0;
    send(0, 0, 8'h55);
    wait_vld(0, "bp_rsp");
    tick();
    req1_vld = 1; req1_mode = 0; req1_data = 8'hA7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_vld_hold", 32'(rsp0_vld), 32'd1);
      chk("bp_data_hold", 32'(rsp_data), 32'(sdes(KEY_A, 1'b0, 8'h55)));
      chk("bp_rdy0", 32'(req0_rdy), 32'd0);
      chk("bp_rdy1", 32'(req1_rdy), 32'd0);
      tick();
    end
    rsp0_rdy = 1;
    @(negedge clk);
    chk("bp_release_vld", 32'(rsp0_vld), 32'd1);
    tick();
    @(negedge clk);
    chk("bp_next_grant", 32'(req1_rdy), 32'd1);
    chk("bp_idle", 32'(busy), 32'd0);
    tick();
    req1_vld = 0;
    wait_vld(1, "bp_rsp1");
    wait_idle("bp_idle2");

    // Key write during WAIT is deferred to the next IDLE cycle.
    tick();
    send(0, 0, 8'hC3);
    tick();
    cfg_key_vld = 1; cfg_key = 10'h3FF;
    tick();
    cfg_key_vld = 0;
    req1_vld = 1; req1_mode = 1; req1_data = 8'h5A;
    wait_vld(0, "key_rsp");
    chk("key_held_resp", 32'(core_key), 32'(KEY_A));
    tick();
    @(negedge clk);
    chk("key_idle_busy", 32'(busy), 32'd0);
    chk("key_grant_delayed", 32'(req1_rdy), 32'd0);
    chk("key_old_in_idle", 32'(core_key), 32'(KEY_A));
    tick();
    @(negedge clk);
    chk("key_new", 32'(core_key), 32'h3FF);
    chk("key_grant_after", 32'(req1_rdy), 32'd1);
    tick();
    req1_vld = 0;
    wait_vld(1, "key_rsp1");
    wait_idle("key_idle");

    // Reset in the middle of a job.
    tick();
    send(1, 0, 8'h3C);
    tick();
    tick();
    rst = 1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_key", 32'(core_key), 32'd0);
    chk("mrst_jobs", 32'(job_cnt), 32'd0);
    chk("mrst_rsp1", 32'(rsp1_vld), 32'd0);
    chk("mrst_en", 32'({core_en_enc, core_en_dec}), 32'd0);
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      chk("mrst_no_rsp", 32'({rsp0_vld, rsp1_vld}), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
